perf_counter_bank: RTL and testbench

Parametrised performance-counter bank for the CPU datapath: one free-running cycle counter plus NUM_EVT event counters (jump, branch-taken, stall, etc.), all frozen while the CPU is halted. Adds selectable wrap/saturate arithmetic, sticky overflow flags, shadow snapshots, and an optional fixed-length sampling window. The bank sits beside the CPU core and feeds the board display/debug mux through a single indexed read port.

---
 rtl/perf_counter_bank.sv | 103 ++++++++++
 tb/tb_perf_counter_bank.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// Performance-counter bank: a free-running cycle counter plus NUM_EVT gated event
// counters, with wrap/saturate arithmetic, sticky overflow, shadow snapshots and an optional sampling window.
module perf_counter_bank #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_EVT  = 4,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned PERIOD   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stop,
  input  logic [NUM_EVT-1:0] evt,
  input  logic [NUM_EVT-1:0] en,
  input  logic               clr,
  input  logic               snap,
  input  logic [3:0]         sel,
  output logic [WIDTH-1:0]   rd_data,
  output logic [NUM_EVT:0]   ovf,
  output logic               snap_valid
);

  localparam int unsigned NCH = NUM_EVT + 1;
  localparam int unsigned WCW = (PERIOD > 1) ? $clog2(PERIOD) + 1 : 1;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [NCH-1:0]   inc_c;
  logic [NCH-1:0]   wrap_c;
  logic [WIDTH-1:0] live   [NCH];
  logic [WIDTH-1:0] shadow [NCH];
  logic [WIDTH-1:0] nxt_c  [NCH];
  logic             win_end_c;
  logic             snap_now_c;

  // Channel 0 counts every running cycle; channel i counts enabled events.
  assign inc_c = {evt & en & {NUM_EVT{~stop}}, ~stop};

  // Next value per channel, including wrap/saturate at all-ones.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      nxt_c[i]  = live[i];
      wrap_c[i] = 1'b0;
      if (inc_c[i]) begin
        if (live[i] == ALL_ONES) begin
          wrap_c[i] = 1'b1;
          nxt_c[i]  = (SATURATE != 0) ? ALL_ONES : '0;
        end else begin
          nxt_c[i] = live[i] + WIDTH'(1);
        end
      end
    end
  end

  // Sampling window: counts running cycles, fires on the last one.
  if (PERIOD > 0) begin : g_win
    logic [WCW-1:0] win;

    assign win_end_c = ~stop & (win == WCW'(PERIOD - 1));

    always_ff @(posedge clk) begin
      if (rst || clr) begin
        win <= '0;
      end else if (!stop) begin
        win <= win_end_c ? '0 : win + WCW'(1);
      end
    end
  end else begin : g_nowin
    assign win_end_c = 1'b0;
  end

  assign snap_now_c = win_end_c | snap;

  // Live counters, shadows and sticky flags; clr behaves like a reset of bank state.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        live[i]   <= '0;
        shadow[i] <= '0;
      end
      ovf        <= '0;
      snap_valid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        live[i] <= win_end_c ? '0 : nxt_c[i];
        if (snap_now_c) begin
          shadow[i] <= nxt_c[i];
        end
      end
      ovf        <= ovf | wrap_c;
      snap_valid <= snap_now_c;
    end
  end

  // Indexed read of the shadows; out-of-range indices read as zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sel == 4'(i)) begin
        rd_data = shadow[i];
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank: four configurations (plain, 4-bit wrap,
// 4-bit saturate, 8-cycle window), expected snapshots queued by stimulus and checked by a monitor.
`timescale 1ns/1ps
module tb_perf_counter_bank;

  typedef struct packed {
    logic [1:0]       dut;
    logic             probe;
    logic [4:0][31:0] v;
    logic [4:0]       ovf;
  } exp_t;

  logic clk;
  logic [3:0] rst, stop, clr, snap, sv, probe;
  logic [3:0] evt [4];
  logic [3:0] en  [4];
  logic [3:0] sel [4];
  logic [4:0] ovf [4];
  logic [31:0] rd0, rd3;
  logic [3:0]  rd1, rd2;
  bit done = 1'b0;
  int total = 0;
  int bad = 0;
  exp_t q[$];

  perf_counter_bank #(.WIDTH(32), .NUM_EVT(4), .SATURATE(0), .PERIOD(0)) u_a (
    .clk(clk), .rst(rst[0]), .stop(stop[0]), .evt(evt[0]), .en(en[0]), .clr(clr[0]),
    .snap(snap[0]), .sel(sel[0]), .rd_data(rd0), .ovf(ovf[0]), .snap_valid(sv[0]));
  perf_counter_bank #(.WIDTH(4), .NUM_EVT(4), .SATURATE(0), .PERIOD(0)) u_b (
    .clk(clk), .rst(rst[1]), .stop(stop[1]), .evt(evt[1]), .en(en[1]), .clr(clr[1]),
    .snap(snap[1]), .sel(sel[1]), .rd_data(rd1), .ovf(ovf[1]), .snap_valid(sv[1]));
  perf_counter_bank #(.WIDTH(4), .NUM_EVT(4), .SATURATE(1), .PERIOD(0)) u_c (
    .clk(clk), .rst(rst[2]), .stop(stop[2]), .evt(evt[2]), .en(en[2]), .clr(clr[2]),
    .snap(snap[2]), .sel(sel[2]), .rd_data(rd2), .ovf(ovf[2]), .snap_valid(sv[2]));
  perf_counter_bank #(.WIDTH(32), .NUM_EVT(4), .SATURATE(0), .PERIOD(8)) u_d (
    .clk(clk), .rst(rst[3]), .stop(stop[3]), .evt(evt[3]), .en(en[3]), .clr(clr[3]),
    .snap(snap[3]), .sel(sel[3]), .rd_data(rd3), .ovf(ovf[3]), .snap_valid(sv[3]));

  initial clk = 1'b0;
  always #50 clk = ~clk;

  function automatic logic [31:0] rd_of(input int d);
    case (d)
      0:       return rd0;
      1:       return 32'(rd1);
      2:       return 32'(rd2);
      default: return rd3;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int d, input logic pr, input logic [31:0] v0, input logic [31:0] v1,
                      input logic [31:0] v2, input logic [31:0] v3, input logic [31:0] v4,
                      input logic [4:0] o);
    exp_t e;
    e.dut   = 2'(d);
    e.probe = pr;
    e.v[0]  = v0;
    e.v[1]  = v1;
    e.v[2]  = v2;
    e.v[3]  = v3;
    e.v[4]  = v4;
    e.ovf   = o;
    q.push_back(e);
  endtask

  // Monitor: on a snap_valid pulse or a probe request, pop and compare one entry.
  initial begin
    exp_t e;
    logic [31:0] want, got;
    logic [3:0] k;
    for (int d = 0; d < 4; d++) sel[d] = 4'd0;
    forever begin
      @(negedge clk);
      if (done) begin
        total++;
        if (q.size() != 0) begin
          bad++;
          $display("FAIL leftover_expect got=%0d pending want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
      for (int d = 0; d < 4; d++) begin
        if (sv[d] === 1'b1 || probe[d]) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL stray_pulse dut=%0d got snap_valid=%b want no pulse", d, sv[d]);
          end else begin
            e = q.pop_front();
            if (int'(e.dut) != d || sv[d] !== ~e.probe) begin
              bad++;
              $display("FAIL pulse dut=%0d got snap_valid=%b want dut=%0d snap_valid=%b",
                       d, sv[d], e.dut, ~e.probe);
            end
            for (int j = 0; j < 7; j++) begin
              k = (j == 6) ? 4'd15 : 4'(j);
              sel[d] = k;
              #1;
              if (j < 5) want = e.v[j];
              else       want = 32'd0;
              got = rd_of(d);
              total++;
              if (got !== want) begin
                bad++;
                $display("FAIL rd_data dut=%0d sel=%0d got=%0d want=%0d", d, k, got, want);
              end
            end
            total++;
            if (ovf[d] !== e.ovf) begin
              bad++;
              $display("FAIL ovf dut=%0d got=%b want=%b", d, ovf[d], e.ovf);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    rst = 4'hF; stop = 4'hF; clr = 4'h0; snap = 4'h0; probe = 4'h0;
    for (int d = 0; d < 4; d++) begin
      evt[d] = 4'h0;
      en[d]  = 4'h0;
    end
    step(2);
    rst = 4'h0;
    for (int d = 0; d < 4; d++) push(d, 1'b1, 0, 0, 0, 0, 0, 5'b0);
    probe = 4'hF;
    step(1);
    probe = 4'h0;

    // 10 running cycles, the tenth with snap
    stop[0] = 1'b0;
    step(9);
    snap[0] = 1'b1;
    push(0, 1'b0, 10, 0, 0, 0, 0, 5'b0);
    step(1);
    snap[0] = 1'b0; stop[0] = 1'b1;
    step(1);

    // enable mask, halt gating, stop+snap, manual snap keeps live
    clr[0] = 1'b1;
    step(1);
    clr[0] = 1'b0; stop[0] = 1'b0; evt[0] = 4'b0001; en[0] = 4'b0000;
    step(5);
    en[0] = 4'b0001;
    step(3);
    stop[0] = 1'b1;
    step(4);
    stop[0] = 1'b0; evt[0] = 4'b1110; en[0] = 4'b1010;
    step(2);
    evt[0] = 4'b0000; snap[0] = 1'b1;
    push(0, 1'b0, 11, 3, 2, 0, 2, 5'b0);
    step(1);
    stop[0] = 1'b1;
    push(0, 1'b0, 11, 3, 2, 0, 2, 5'b0);
    step(1);
    stop[0] = 1'b0;
    push(0, 1'b0, 12, 3, 2, 0, 2, 5'b0);
    step(1);
    snap[0] = 1'b0; stop[0] = 1'b1;
    step(1);

    // 4-bit wrap vs saturate after 17 counted cycles, then clr
    clr[1] = 1'b1; clr[2] = 1'b1;
    step(1);
    clr[1] = 1'b0; clr[2] = 1'b0; stop[1] = 1'b0; stop[2] = 1'b0;
    step(16);
    snap[1] = 1'b1; snap[2] = 1'b1;
    push(1, 1'b0, 1, 0, 0, 0, 0, 5'b00001);
    push(2, 1'b0, 15, 0, 0, 0, 0, 5'b00001);
    step(1);
    snap[1] = 1'b0; snap[2] = 1'b0; stop[1] = 1'b1; stop[2] = 1'b1;
    step(1);
    clr[1] = 1'b1; clr[2] = 1'b1;
    step(1);
    clr[1] = 1'b0; clr[2] = 1'b0;
    push(1, 1'b1, 0, 0, 0, 0, 0, 5'b0);
    push(2, 1'b1, 0, 0, 0, 0, 0, 5'b0);
    probe = 4'b0110;
    step(1);
    probe = 4'h0;

    // 8-cycle window with a halt inside and a coincident manual snap
    clr[3] = 1'b1;
    step(1);
    clr[3] = 1'b0; stop[3] = 1'b0; evt[3] = 4'b0010; en[3] = 4'b1111;
    for (int w = 0; w < 3; w++) push(3, 1'b0, 8, 0, 8, 0, 0, 5'b0);
    step(8);
    step(4);
    stop[3] = 1'b1;
    step(3);
    stop[3] = 1'b0;
    step(4);
    step(7);
    snap[3] = 1'b1;
    step(1);
    snap[3] = 1'b0;

    // clr with snap after 6 counted cycles restarts the window
    step(6);
    clr[3] = 1'b1; snap[3] = 1'b1;
    step(1);
    clr[3] = 1'b0; snap[3] = 1'b0;
    push(3, 1'b1, 0, 0, 0, 0, 0, 5'b0);
    push(3, 1'b0, 8, 0, 8, 0, 0, 5'b0);
    probe[3] = 1'b1;
    step(1);
    probe[3] = 1'b0;
    step(7);

    // reset mid-window
    step(5);
    rst[3] = 1'b1;
    step(1);
    rst[3] = 1'b0;
    push(3, 1'b1, 0, 0, 0, 0, 0, 5'b0);
    push(3, 1'b0, 8, 0, 8, 0, 0, 5'b0);
    probe[3] = 1'b1;
    step(1);
    probe[3] = 1'b0;
    step(7);
    stop[3] = 1'b1;
    step(3);
    done = 1'b1;
  end

endmodule
